// File: rtl/mul_sequencer.sv
// Shift-add multiply sequencer for the MUL instruction: stalls the CPU while it
// iterates over the multiplier bits, then pulses done for one write-back cycle.
module mul_sequencer #(
   parameter int WIDTH      = 64,
   parameter bit EARLY_EXIT = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             stall,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   // state | meaning
   // IDLE  | waiting for a decoded MUL; stall follows start combinationally
   // CALC  | one multiplier bit consumed per cycle, CPU frozen
   // DONE  | result valid, CPU writes back this cycle; start ignored
   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] mcand, mplier, acc;
   logic [WIDTH-1:0] acc_upd, mplier_sh;
   logic [CW-1:0]    cnt;
   logic             last, load, finish;

   assign acc_upd   = mplier[0] ? acc + mcand : acc;
   assign mplier_sh = mplier >> 1;
   assign last      = (cnt == LAST_CNT) || (EARLY_EXIT && (mplier_sh == '0));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      stall     = 1'b0;
      load      = 1'b0;
      finish    = 1'b0;
      case (state)
         S_IDLE: begin
            if (start && !abort) begin
               stall     = 1'b1;
               load      = 1'b1;
               state_nxt = S_CALC;
            end
         end
         S_CALC: begin
            stall = 1'b1;
            // abort outranks completion: no result update, no done pulse
            if (abort) begin
               state_nxt = S_IDLE;
            end else if (last) begin
               finish    = 1'b1;
               state_nxt = S_DONE;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   assign busy = (state == S_CALC);
   assign done = (state == S_DONE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         cnt    <= '0;
         result <= '0;
      end else if (load) begin
         mcand  <= op_a;
         mplier <= op_b;
         acc    <= '0;
         cnt    <= '0;
      end else if (state == S_CALC) begin
         acc    <= acc_upd;
         mcand  <= mcand << 1;
         mplier <= mplier_sh;
         cnt    <= cnt + CW'(1);
         if (finish) result <= acc_upd;
      end
   end

endmodule

// File: tb/tb_mul_sequencer.sv
// Randomised bench for mul_sequencer: a product/latency model drives expected
// done timing and result for an early-exit and a fixed-length instance.
module tb_mul_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start1 = 1'b0, start0 = 1'b0;
   logic        abort = 1'b0;
   logic [63:0] op_a = '0, op_b = '0;
   logic        stall1, busy1, done1, stall0, busy0, done0;
   logic [63:0] result1, result0;

   int checks = 0;
   int failures = 0;
   bit use0 = 1'b0;
   logic [63:0] exp_res1 = '0, exp_res0 = '0;

   logic        obs_stall, obs_busy, obs_done;
   logic [63:0] obs_result;
   assign obs_stall  = use0 ? stall0  : stall1;
   assign obs_busy   = use0 ? busy0   : busy1;
   assign obs_done   = use0 ? done0   : done1;
   assign obs_result = use0 ? result0 : result1;

   always #5 clk = ~clk;

   mul_sequencer #(.WIDTH(64), .EARLY_EXIT(1'b1)) u_dut (
      .clk(clk), .reset(reset), .start(start1), .abort(abort),
      .op_a(op_a), .op_b(op_b),
      .stall(stall1), .busy(busy1), .done(done1), .result(result1));

   mul_sequencer #(.WIDTH(64), .EARLY_EXIT(1'b0)) u_dut0 (
      .clk(clk), .reset(reset), .start(start0), .abort(abort),
      .op_a(op_a), .op_b(op_b),
      .stall(stall0), .busy(busy0), .done(done0), .result(result0));

   // Number of CALC cycles the operation should take.
   function automatic int model_len(input logic [63:0] b, input bit ee);
      if (!ee) return 64;
      for (int i = 63; i >= 0; i--)
         if (b[i]) return i + 1;
      return 1;
   endfunction

   function automatic logic [63:0] cur_exp();
      return use0 ? exp_res0 : exp_res1;
   endfunction

   // Launch one op on the selected instance, check every cycle up to done.
   task automatic run_op(input logic [63:0] a, input logic [63:0] b, input bit hold);
      logic [63:0] prod;
      logic [63:0] got;
      int n;
      int bad_k;
      prod  = a * b;
      n     = model_len(b, !use0);
      bad_k = -1;
      got   = '0;
      @(posedge clk); #1;
      op_a = a; op_b = b;
      if (use0) start0 = 1'b1; else start1 = 1'b1;
      @(negedge clk);
      if (obs_stall !== 1'b1 || obs_busy !== 1'b0 || obs_done !== 1'b0) bad_k = 0;
      for (int k = 1; k <= n + 1; k++) begin
         @(posedge clk); #1;
         if (!hold) begin start0 = 1'b0; start1 = 1'b0; end
         op_a = {$urandom, $urandom};
         op_b = {$urandom, $urandom};
         @(negedge clk);
         if (bad_k < 0 && (obs_busy !== 1'(k <= n) || obs_stall !== 1'(k <= n) ||
                           obs_done !== 1'(k == n + 1)))
            bad_k = k;
         if (k == n + 1) got = obs_result;
      end
      checks++;
      if (bad_k >= 0) begin
         failures++;
         $display("FAIL op_timing: a=%h b=%h first wrong cycle t%0d (stall=%b busy=%b done=%b), expected done at t%0d",
                  a, b, bad_k, obs_stall, obs_busy, obs_done, n + 1);
      end
      checks++;
      if (got !== prod) begin
         failures++;
         $display("FAIL op_result: a=%h b=%h got %h expected %h", a, b, got, prod);
      end
      if (use0) exp_res0 = prod; else exp_res1 = prod;
      if (!hold) begin
         @(posedge clk); #1;
         @(negedge clk);
         checks++;
         if (obs_stall !== 1'b0 || obs_busy !== 1'b0 || obs_done !== 1'b0 || obs_result !== prod) begin
            failures++;
            $display("FAIL op_idle_after: stall=%b busy=%b done=%b result=%h expected 0/0/0/%h",
                     obs_stall, obs_busy, obs_done, obs_result, prod);
         end
      end
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if ({busy1, done1, busy0, done0, stall1, stall0} !== 6'b0 || result1 !== '0 || result0 !== '0) begin
         failures++;
         $display("FAIL reset_outputs: busy=%b done=%b stall=%b result=%h, expected all zero",
                  busy1, done1, stall1, result1);
      end
      start1 = 1'b1; #1;
      checks++;
      if (stall1 !== 1'b1) begin
         failures++;
         $display("FAIL reset_stall_tracks_start: stall=%b expected 1", stall1);
      end
      start1 = 1'b0; #1;
      checks++;
      if (stall1 !== 1'b0 || busy1 !== 1'b0) begin
         failures++;
         $display("FAIL reset_stall_release: stall=%b busy=%b expected 0/0", stall1, busy1);
      end
      @(posedge clk); #1;
      reset = 1'b1;
   endtask

   task automatic test_basic();
      use0 = 1'b0;
      run_op(64'd3, 64'd5, 1'b0);
      run_op(64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 1'b0);
      run_op(64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      run_op(64'h0123_4567_89AB_CDEF, 64'd0, 1'b0);
      run_op(64'hDEAD_BEEF_0000_0001, 64'h8000_0000_0000_0000, 1'b0);
   endtask

   task automatic test_fixed_length();
      use0 = 1'b1;
      run_op(64'h0000_0000_1234_5678, 64'd2, 1'b0);
      run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 1'b0);
      use0 = 1'b0;
   endtask

   task automatic test_back_to_back();
      use0 = 1'b0;
      run_op(64'h55, 64'd0, 1'b1);
      run_op(64'd3, 64'd5, 1'b1);
      run_op(64'd11, 64'd13, 1'b0);
   endtask

   task automatic test_abort();
      int seen;
      logic [63:0] keep;
      use0 = 1'b0;
      keep = exp_res1;
      @(posedge clk); #1;
      op_a = 64'd3; op_b = '1; start1 = 1'b1;
      @(posedge clk); #1; start1 = 1'b0;
      @(posedge clk); #1; abort = 1'b1;
      @(posedge clk); #1; abort = 1'b0;
      @(negedge clk);
      checks++;
      if (stall1 !== 1'b0 || busy1 !== 1'b0 || done1 !== 1'b0 || result1 !== keep) begin
         failures++;
         $display("FAIL abort_mid_calc: stall=%b busy=%b done=%b result=%h expected 0/0/0/%h",
                  stall1, busy1, done1, result1, keep);
      end
      seen = 0;
      for (int k = 0; k < 70; k++) begin
         @(negedge clk);
         if (done1 !== 1'b0 || busy1 !== 1'b0) seen++;
      end
      checks++;
      if (seen != 0) begin
         failures++;
         $display("FAIL abort_no_done: %0d active cycles after abort, expected 0", seen);
      end
      // abort on the completing CALC cycle
      @(posedge clk); #1;
      op_a = 64'd3; op_b = 64'd5; start1 = 1'b1;
      @(posedge clk); #1; start1 = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1; abort = 1'b1;
      @(posedge clk); #1; abort = 1'b0;
      @(negedge clk);
      checks++;
      if (done1 !== 1'b0 || busy1 !== 1'b0 || result1 !== keep) begin
         failures++;
         $display("FAIL abort_on_finish: done=%b busy=%b result=%h expected 0/0/%h",
                  done1, busy1, result1, keep);
      end
      @(posedge clk); #1;
      start1 = 1'b1; abort = 1'b1;
      @(negedge clk);
      checks++;
      if (stall1 !== 1'b0) begin
         failures++;
         $display("FAIL start_with_abort_stall: stall=%b expected 0", stall1);
      end
      @(posedge clk); #1;
      start1 = 1'b0; abort = 1'b0;
      @(negedge clk);
      checks++;
      if (busy1 !== 1'b0) begin
         failures++;
         $display("FAIL start_with_abort_accept: busy=%b expected 0", busy1);
      end
   endtask

   task automatic test_random();
      logic [63:0] a, b;
      for (int i = 0; i < 24; i++) begin
         a = {$urandom, $urandom};
         b = {$urandom, $urandom} >> $urandom_range(0, 63);
         if ($urandom_range(0, 7) == 0) b = '0;
         use0 = ($urandom_range(0, 3) == 0);
         run_op(a, b, 1'b0);
      end
      use0 = 1'b0;
   endtask

   task automatic test_async_reset();
      use0 = 1'b0;
      run_op(64'd7, 64'd9, 1'b0);
      @(posedge clk); #1;
      op_a = 64'd3; op_b = '1; start1 = 1'b1;
      @(posedge clk); #1; start1 = 1'b0;
      @(posedge clk); #2;
      reset = 1'b0;
      #1;
      checks++;
      if (busy1 !== 1'b0 || done1 !== 1'b0 || result1 !== '0 || stall1 !== 1'b0) begin
         failures++;
         $display("FAIL async_reset_mid_calc: busy=%b done=%b stall=%b result=%h expected 0/0/0/0",
                  busy1, done1, stall1, result1);
      end
      exp_res1 = '0;
      exp_res0 = '0;
      @(posedge clk); #1;
      reset = 1'b1;
      run_op(64'd3, 64'd5, 1'b0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_fixed_length();
      test_back_to_back();
      test_abort();
      test_random();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
